// File: rtl/fetch_unit_if.sv
// Bundles the fetch stage's control handshake, instruction-memory port and
// IF/ID / status outputs so they travel as one port.
interface fetch_unit_if #(
    parameter int PC_W    = 9,
    parameter int INSTR_W = 16,
    parameter int IMM_W   = 8
);
    logic [3:0]         pc_sel;
    logic               load_pc;
    logic               load_if;
    logic [IMM_W-1:0]   br_imm;
    logic [15:0]        reg_target;
    logic [INSTR_W-1:0] imem_rdata;
    logic [PC_W-1:0]    imem_addr;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] if_instr;
    logic [PC_W-1:0]    if_pc_plus1;
    logic               if_valid;
    logic [PC_W-1:0]    link_addr;
    logic               halted;
    logic               sel_err;
    logic [15:0]        fetch_count;
    logic [15:0]        flush_count;

    // The fetch unit consumes the control handshake and drives everything else.
    modport slave (
        input  pc_sel, load_pc, load_if, br_imm, reg_target, imem_rdata,
        output imem_addr, pc, if_instr, if_pc_plus1, if_valid, link_addr,
               halted, sel_err, fetch_count, flush_count
    );

    modport master (
        output pc_sel, load_pc, load_if, br_imm, reg_target, imem_rdata,
        input  imem_addr, pc, if_instr, if_pc_plus1, if_valid, link_addr,
               halted, sel_err, fetch_count, flush_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, link address,
// fetch/flush statistics and a sticky illegal-select flag.
module fetch_unit #(
    parameter int PC_W      = 9,
    parameter int INSTR_W   = 16,
    parameter int IMM_W     = 8,
    parameter int RESET_VEC = 0,
    parameter int NOP_INSTR = 0
) (
    input logic        clk,
    input logic        reset,
    fetch_unit_if.slave bus
);
    localparam logic [PC_W-1:0]    RESET_PC = PC_W'(RESET_VEC);
    localparam logic [INSTR_W-1:0] NOP      = INSTR_W'(NOP_INSTR);

    logic [PC_W-1:0]    pc_q;
    logic [INSTR_W-1:0] if_instr_q;
    logic [PC_W-1:0]    if_pc_plus1_q;
    logic               if_valid_q;
    logic               halted_q;
    logic               sel_err_q;
    logic [15:0]        fetch_count_q;
    logic [15:0]        flush_count_q;

    logic [PC_W-1:0]    imm_ext;
    logic [PC_W-1:0]    target_pc;
    logic               sel_legal;
    logic               capture;
    logic               flush;
    logic               unused_reg_bits;

    assign imm_ext         = PC_W'($signed(bus.br_imm));
    assign capture         = bus.load_if;
    assign flush           = bus.load_pc && !bus.load_if;
    assign unused_reg_bits = ^bus.reg_target;

    // Relative targets are based on the ID-stage branch's own PC + 1.
    always_comb begin
        target_pc = pc_q;
        sel_legal = 1'b1;
        case (bus.pc_sel)
            4'b0001: target_pc = RESET_PC;
            4'b0010: target_pc = pc_q + 1'b1;
            4'b0100: target_pc = if_pc_plus1_q + imm_ext;
            4'b1000: target_pc = bus.reg_target[PC_W-1:0];
            default: sel_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            sel_err_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            if (bus.load_pc && sel_legal) begin
                pc_q <= target_pc;
            end
            if (bus.load_pc && !sel_legal) begin
                sel_err_q <= 1'b1;
            end
            halted_q <= !(bus.load_pc || bus.load_if);
        end
    end

    // Flush keeps if_pc_plus1 so the link address survives the bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_instr_q    <= NOP;
            if_pc_plus1_q <= '0;
            if_valid_q    <= 1'b0;
        end else if (capture) begin
            if_instr_q    <= bus.imem_rdata;
            if_pc_plus1_q <= pc_q + 1'b1;
            if_valid_q    <= 1'b1;
        end else if (flush) begin
            if_instr_q <= NOP;
            if_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            if (capture && fetch_count_q != 16'hFFFF) begin
                fetch_count_q <= fetch_count_q + 16'd1;
            end
            if (flush && flush_count_q != 16'hFFFF) begin
                flush_count_q <= flush_count_q + 16'd1;
            end
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.if_instr    = if_instr_q;
    assign bus.if_pc_plus1 = if_pc_plus1_q;
    assign bus.if_valid    = if_valid_q;
    assign bus.link_addr   = if_pc_plus1_q;
    assign bus.halted      = halted_q;
    assign bus.sel_err     = sel_err_q;
    assign bus.fetch_count = fetch_count_q;
    assign bus.flush_count = flush_count_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// traffic compared against an arithmetic reference model of the fetch stage.
module tb_fetch_unit;
    localparam int PC_W  = 9;
    localparam int DEPTH = 512;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [15:0] mem [DEPTH];

    int m_pc, m_ifpc1, m_instr, m_valid, m_halted, m_selerr, m_fetch, m_flush;

    fetch_unit_if #(.PC_W(9), .INSTR_W(16), .IMM_W(8)) bus ();

    fetch_unit #(
        .PC_W(9), .INSTR_W(16), .IMM_W(8), .RESET_VEC(0), .NOP_INSTR(0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.imem_rdata = mem[bus.imem_addr];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".pc"}, 32'(bus.pc), m_pc);
        checkOutput({tag, ".imem_addr"}, 32'(bus.imem_addr), m_pc);
        checkOutput({tag, ".if_instr"}, 32'(bus.if_instr), m_instr);
        checkOutput({tag, ".if_pc_plus1"}, 32'(bus.if_pc_plus1), m_ifpc1);
        checkOutput({tag, ".if_valid"}, 32'(bus.if_valid), m_valid);
        checkOutput({tag, ".link_addr"}, 32'(bus.link_addr), m_ifpc1);
        checkOutput({tag, ".halted"}, 32'(bus.halted), m_halted);
        checkOutput({tag, ".sel_err"}, 32'(bus.sel_err), m_selerr);
        checkOutput({tag, ".fetch_count"}, 32'(bus.fetch_count), m_fetch);
        checkOutput({tag, ".flush_count"}, 32'(bus.flush_count), m_flush);
    endtask

    function automatic void modelReset();
        m_pc = 0; m_ifpc1 = 0; m_instr = 0; m_valid = 0;
        m_halted = 0; m_selerr = 0; m_fetch = 0; m_flush = 0;
    endfunction

    // One clock edge of the fetch stage, written as plain modular arithmetic.
    function automatic void modelStep(input logic [3:0] sel, input logic lpc, input logic lif,
                                      input logic [7:0] imm, input logic [15:0] rt);
        int old_pc = m_pc;
        int simm = int'(imm);
        if (simm >= 128) simm -= 256;
        if (lpc) begin
            if (sel == 4'b0001)      m_pc = 0;
            else if (sel == 4'b0010) m_pc = (old_pc + 1) % DEPTH;
            else if (sel == 4'b0100) m_pc = (m_ifpc1 + simm + DEPTH) % DEPTH;
            else if (sel == 4'b1000) m_pc = int'(rt) % DEPTH;
            else                     m_selerr = 1;
        end
        if (lif) begin
            m_instr = int'(mem[old_pc]);
            m_ifpc1 = (old_pc + 1) % DEPTH;
            m_valid = 1;
            if (m_fetch < 65535) m_fetch++;
        end else if (lpc) begin
            m_instr = 0;
            m_valid = 0;
            if (m_flush < 65535) m_flush++;
        end
        m_halted = (lpc || lif) ? 0 : 1;
    endfunction

    task automatic applyStimulus(input string tag, input logic [3:0] sel, input logic lpc,
                                 input logic lif, input logic [7:0] imm, input logic [15:0] rt,
                                 input bit check);
        bus.pc_sel = sel;
        bus.load_pc = lpc;
        bus.load_if = lif;
        bus.br_imm = imm;
        bus.reg_target = rt;
        #2;
        if (check) checkOutput({tag, ".link_pre"}, 32'(bus.link_addr), m_ifpc1);
        @(posedge clk);
        modelStep(sel, lpc, lif, imm, rt);
        #1;
        if (check) checkAll(tag);
    endtask

    task automatic doReset();
        @(negedge clk);
        bus.load_pc = 1'b0;
        bus.load_if = 1'b0;
        reset = 1'b1;
        modelReset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.pc_sel = 4'b0010;
        bus.load_pc = 1'b0;
        bus.load_if = 1'b0;
        bus.br_imm = '0;
        bus.reg_target = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h1111;
        mem[1] = 16'h2222;
        mem[2] = 16'h3333;

        doReset();
        #1;
        checkAll("reset");

        for (int i = 0; i < 3; i++) applyStimulus("seq", 4'b0010, 1'b1, 1'b1, 8'h00, 16'h0, 1'b1);
        checkOutput("seq3.pc", 32'(bus.pc), 3);
        checkOutput("seq3.if_instr", 32'(bus.if_instr), 32'h3333);
        checkOutput("seq3.if_pc_plus1", 32'(bus.if_pc_plus1), 3);
        checkOutput("seq3.fetch_count", 32'(bus.fetch_count), 3);
        checkOutput("seq3.if_valid", 32'(bus.if_valid), 1);

        for (int i = 0; i < 3; i++) applyStimulus("seq", 4'b0010, 1'b1, 1'b1, 8'h00, 16'h0, 1'b1);
        checkOutput("rel.link_before", 32'(bus.link_addr), 6);
        applyStimulus("rel", 4'b0100, 1'b1, 1'b0, 8'hFC, 16'h0, 1'b1);
        checkOutput("rel.pc", 32'(bus.pc), 2);
        checkOutput("rel.if_valid", 32'(bus.if_valid), 0);
        checkOutput("rel.if_instr", 32'(bus.if_instr), 0);
        checkOutput("rel.flush_count", 32'(bus.flush_count), 1);
        checkOutput("rel.link_after", 32'(bus.link_addr), 6);

        applyStimulus("regbr", 4'b1000, 1'b1, 1'b0, 8'h00, 16'h0203, 1'b1);
        checkOutput("regbr.pc", 32'(bus.pc), 32'h003);
        applyStimulus("regbr2", 4'b1000, 1'b1, 1'b0, 8'h00, 16'h01FF, 1'b1);
        applyStimulus("wrap", 4'b0010, 1'b1, 1'b1, 8'h00, 16'h0, 1'b1);
        checkOutput("wrap.pc", 32'(bus.pc), 0);
        checkOutput("wrap.if_pc_plus1", 32'(bus.if_pc_plus1), 0);

        for (int i = 0; i < 4; i++)
            applyStimulus("freeze", 4'($urandom), 1'b0, 1'b0, 8'($urandom), 16'($urandom), 1'b1);
        checkOutput("freeze.halted", 32'(bus.halted), 1);
        checkOutput("freeze.pc", 32'(bus.pc), 0);
        applyStimulus("resume", 4'b0010, 1'b1, 1'b1, 8'h00, 16'h0, 1'b1);
        checkOutput("resume.halted", 32'(bus.halted), 0);
        checkOutput("resume.if_pc_plus1", 32'(bus.if_pc_plus1), 1);
        checkOutput("resume.pc", 32'(bus.pc), 1);

        applyStimulus("illegal", 4'b0110, 1'b1, 1'b0, 8'h00, 16'h0, 1'b1);
        checkOutput("illegal.pc", 32'(bus.pc), 1);
        checkOutput("illegal.sel_err", 32'(bus.sel_err), 1);
        checkOutput("illegal.if_valid", 32'(bus.if_valid), 0);
        for (int i = 0; i < 2; i++) applyStimulus("sticky", 4'b0010, 1'b1, 1'b1, 8'h00, 16'h0, 1'b1);
        checkOutput("sticky.sel_err", 32'(bus.sel_err), 1);

        doReset();
        #1;
        checkAll("reset2");
        for (int i = 0; i < 400; i++) begin
            int r = $urandom_range(0, 9);
            logic [3:0] sel;
            sel = (r < 8) ? 4'(1 << (r % 4)) : 4'($urandom_range(0, 15));
            applyStimulus("rand", sel, 1'($urandom), 1'($urandom), 8'($urandom), 16'($urandom), 1'b1);
        end

        doReset();
        for (int i = 0; i < 65540; i++) applyStimulus("sat", 4'b0010, 1'b1, 1'b1, 8'h00, 16'h0, 1'b0);
        checkOutput("sat.fetch_count", 32'(bus.fetch_count), 32'hFFFF);
        checkAll("sat");
        applyStimulus("sat_more", 4'b0010, 1'b1, 1'b1, 8'h00, 16'h0, 1'b1);
        checkOutput("sat_more.fetch_count", 32'(bus.fetch_count), 32'hFFFF);

        @(posedge clk);
        #3;
        reset = 1'b1;
        modelReset();
        #1;
        checkAll("async_reset");
        checkOutput("async_reset.fetch_count", 32'(bus.fetch_count), 0);
        @(negedge clk);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
